// File: rtl/logic_unit_driver_if.sv
// Request/response handshake bundle between the control path and logic_unit_driver.
// master: request producer and response consumer; slave: the driver itself.
`timescale 1ns/1ps
interface logic_unit_driver_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [3:0]       req_op;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_illegal;
    logic             rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_illegal, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_illegal, rsp_zero
    );
endinterface

// File: rtl/logic_unit_driver.sv
// Registered, credit-based front end around the combinational logic_unit:
// issue register drives the ALU, its result is captured into a response FIFO.
//
// state | meaning
// IDLE  | nothing in the issue stage and response FIFO empty
// BUSY  | a request in the issue stage or at least one response buffered
`timescale 1ns/1ps
module logic_unit_driver #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    logic_unit_driver_if.slave    bus,
    output logic [31:0]           alu_input1,
    output logic [31:0]           alu_input2,
    output logic [3:0]            alu_op,
    input  logic [31:0]           alu_result,
    output logic [15:0]           op_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 32 + TAG_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [3:0] OP_AND       = 4'h0;
    localparam logic [3:0] OP_OR        = 4'h1;
    localparam logic [3:0] OP_ADD       = 4'h2;
    localparam logic [3:0] OP_XOR       = 4'h3;
    localparam logic [3:0] OP_SUB       = 4'h6;
    localparam logic [3:0] OP_LESS_THAN = 4'h7;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ready_en;
    logic             iss_valid;
    logic             iss_illegal;
    logic [TAG_W-1:0] iss_tag;
    logic             op_legal;
    logic             accept;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_nxt;
    logic [ENT_W-1:0] mem [DEPTH];

    // Credit counts the entry still in the issue stage so a capture always finds room.
    assign bus.req_ready = ready_en && ((fifo_count + CNT_W'(iss_valid)) < DEPTH_C);
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = iss_valid;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    assign bus.rsp_valid = (state == BUSY) && (fifo_count != '0);
    assign {bus.rsp_result, bus.rsp_tag, bus.rsp_illegal, bus.rsp_zero} = mem[rd_ptr];

    always_comb begin
        op_legal = 1'b0;
        case (bus.req_op)
            OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_LESS_THAN: op_legal = 1'b1;
            default:                                             op_legal = 1'b0;
        endcase
    end

    always_comb begin
        count_nxt = fifo_count;
        case ({push, pop})
            2'b10:   count_nxt = fifo_count + CNT_W'(1);
            2'b01:   count_nxt = fifo_count - CNT_W'(1);
            default: count_nxt = fifo_count;
        endcase
    end

    always_comb begin
        state_nxt = IDLE;
        if (accept || (count_nxt != '0)) begin
            state_nxt = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Holds req_ready low during reset and releases it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid   <= 1'b0;
            iss_illegal <= 1'b0;
            iss_tag     <= '0;
            alu_input1  <= '0;
            alu_input2  <= '0;
            alu_op      <= '0;
        end else begin
            iss_valid <= accept;
            if (accept) begin
                iss_illegal <= !op_legal;
                iss_tag     <= bus.req_tag;
                alu_input1  <= bus.req_a;
                alu_input2  <= bus.req_b;
                alu_op      <= bus.req_op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {alu_result, iss_tag, iss_illegal, (alu_result == 32'h0)};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + 16'd1;
        end
    end
endmodule
